frame_cmd_executor: RTL
=======================

Name: frame_cmd_executor

Overview:
- Consumes validated host frames (frame_valid, CMD, 32-bit address, data bytes) from the frame parser.
- Executes each frame as a burst of single-beat AXI4-Lite master transactions.
- Collects read data into the response buffer and reports one completion status per frame to the response frame builder.
- Returns frame_consumed to the parser once the frame has been fully executed.

Parameters:
- TIMEOUT_CYCLES, 1024, max cycles waiting on any single AXI handshake phase (AW/W, B, AR, R).
- MAX_BEATS, 16, max beats per frame; fixed by the CMD length field.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- frame_valid  in  1  parsed frame available; held until frame_consumed
- frame_consumed  out  1  one-cycle pulse, frame done, parser may release it
- cmd_reg  in  8  [7]=RW (1=read), [6]=INC_DIS (1=fixed addr), [5:4]=SIZE (00=8b, 01=16b, 10=32b, 11=invalid), [3:0]=beats-1
- addr_reg  in  32  start byte address
- data_rd_idx  out  6  byte index into parser data buffer
- data_rd_byte  in  8  combinational read of buffer[data_rd_idx]
- resp_wr_en  out  1  write read-data byte to response buffer
- resp_wr_idx  out  6  response byte index
- resp_wr_byte  out  8  response byte
- done_valid  out  1  completion valid; held until done_ready
- done_ready  in  1  response builder accepts completion
- done_status  out  8  completion status code
- done_beats  out  5  beats completed successfully
- m_awaddr 32 out, m_awvalid 1 out, m_awready 1 in
- m_wdata 32 out, m_wstrb 4 out, m_wvalid 1 out, m_wready 1 in
- m_bresp 2 in, m_bvalid 1 in, m_bready 1 out
- m_araddr 32 out, m_arvalid 1 out, m_arready 1 in
- m_rdata 32 in, m_rresp 2 in, m_rvalid 1 in, m_rready 1 out

Behaviour:
- Reset (rst=0 at posedge): state IDLE. All valid/ready/pulse outputs 0. Addresses, data, strobes, indices, done_status, done_beats all 0.
- Reset mid-transaction abandons the frame with no completion; AXI valids drop next cycle.
- Status codes: 0x00 OK, 0x03 LEN_RANGE (SIZE=11), 0x04 TIMEOUT, 0x05 ADDR_ALIGN (address not aligned to SIZE), 0x06 AXI_ERR (any xRESP != OKAY).
- Bytes per beat: BPB = 1/2/4. Data is little-endian. Beat k uses bytes k*BPB..k*BPB+BPB-1.
- Address per beat: addr + k*BPB, 32-bit wrap-around permitted. If INC_DIS=1, all beats use addr.
- Write lanes: 8b uses lane addr[1:0] with wstrb one-hot; 16b uses lanes {addr[1],0} with wstrb 0011/1100; 32b uses wstrb 1111.
- Read lanes: the same lane selection extracts bytes from m_rdata.
- State IDLE: if frame_valid and done_valid=0, go to CHECK.
- State CHECK (1 cycle): SIZE=11 goes to DONE with 0x03. Misalignment goes to DONE with 0x05. Otherwise beat=0; go to WLOAD if RW=0, else AR.
- State WLOAD: step data_rd_idx over BPB cycles, assembling wdata. Then go to AW_W.
- State AW_W: assert awvalid and wvalid together. Drop each independently on its own handshake (either order, or the same cycle). When both are done, go to B.
- State B: bready=1. On bvalid: BRESP!=0 goes to DONE with 0x06; otherwise goes to NEXT.
- State AR: arvalid until arready. Then go to R.
- State R: rready=1. On rvalid: RRESP!=0 goes to DONE with 0x06. Otherwise write BPB bytes to the response buffer, one per cycle (indices beat*BPB+j), then go to NEXT.
- State NEXT: beat++. If beat==beats-1 before the increment, go to DONE with 0x00. Otherwise go to WLOAD or AR.
- done_beats counts successful beats only; an error beat is not counted.
- State DONE: pulse frame_consumed, set done_valid, go to WAIT_ACK.
- State WAIT_ACK: on done_ready, clear done_valid and go to IDLE.
- A new frame is never started while done_valid=1.
- AXI outputs are stable while valid is high and not yet accepted.

Optional Feature:
- Macro CMD_EXEC_TIMEOUT_EN.
- Defined: a per-phase counter resets on entry to AW_W/B/AR/R.
  - Reaching TIMEOUT_CYCLES without a handshake goes to DONE with status 0x04.
  - All master valid/ready outputs deassert that cycle.
- Undefined: no counter; the executor waits indefinitely in each phase.

Test Plan:
- Write, cmd=0x20 (32b, 1 beat), addr=0x1000, data 11 22 33 44 -> awaddr=0x1000, wdata=0x44332211, wstrb=1111; frame_consumed pulse; done_status=0x00, done_beats=1.
- Read, cmd=0x93 (read, 16b, 4 beats), addr=0x2002 -> araddr 0x2002/0x2004/0x2006/0x2008; 8 resp bytes at idx 0..7; status 0x00, beats 4.
- Byte write, cmd=0x41 (fixed addr, 8b, 2 beats), addr=0x3003 -> both AW at 0x3003 with wstrb=1000; data in wdata[31:24].
- Write with awready 3 cycles before wready, then the same with the order swapped -> exactly one AW and one W handshake each; then B.
- cmd=0xA0 addr=0x4001 -> status 0x05 with no AXI activity. cmd=0x30 -> status 0x03. Read returning rresp=2 on beat 2 of 4 -> status 0x06, beats 1.
- With CMD_EXEC_TIMEOUT_EN and TIMEOUT_CYCLES=8, arready held 0 -> status 0x04 after 8 cycles, arvalid drops. Assert rst mid-burst -> all outputs 0, no done_valid.

Source files
------------

// File: rtl/frame_cmd_executor.sv
// frame_cmd_executor: runs parsed host frames as bursts of AXI4-Lite beats.
// Optional per-phase timeout enabled by defining CMD_EXEC_TIMEOUT_EN.
module frame_cmd_executor #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned MAX_BEATS      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_valid,
    output logic        frame_consumed,
    input  logic [7:0]  cmd_reg,
    input  logic [31:0] addr_reg,
    output logic [5:0]  data_rd_idx,
    input  logic [7:0]  data_rd_byte,
    output logic        resp_wr_en,
    output logic [5:0]  resp_wr_idx,
    output logic [7:0]  resp_wr_byte,
    output logic        done_valid,
    input  logic        done_ready,
    output logic [7:0]  done_status,
    output logic [4:0]  done_beats,
    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready
);

    localparam logic [7:0] ST_OK    = 8'h00;
    localparam logic [7:0] ST_LEN   = 8'h03;
    localparam logic [7:0] ST_TMO   = 8'h04;
    localparam logic [7:0] ST_ALIGN = 8'h05;
    localparam logic [7:0] ST_AXI   = 8'h06;

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_WLOAD, S_AWW, S_B,
        S_AR, S_R, S_RWR, S_NEXT, S_DONE, S_WACK
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cmd;
    logic [31:0] r_addr;
    logic [3:0]  r_beat;
    logic [4:0]  r_beats;
    logic [1:0]  r_j;
    logic [5:0]  r_rcnt;
    logic [31:0] r_rdata;
    logic [7:0]  r_status;
    logic        r_done_valid;
    logic        r_frame_consumed;
    logic [5:0]  r_data_rd_idx;
    logic        r_resp_wr_en;
    logic [5:0]  r_resp_wr_idx;
    logic [7:0]  r_resp_wr_byte;
    logic [31:0] r_awaddr;
    logic        r_awvalid;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_wvalid;
    logic        r_bready;
    logic [31:0] r_araddr;
    logic        r_arvalid;
    logic        r_rready;

    logic        w_rw;
    logic        w_fix;
    logic [1:0]  w_size;
    logic [1:0]  w_bpb_m1;
    logic [3:0]  w_strb;
    logic [1:0]  w_lane;
    logic        w_misal;
    logic [31:0] w_next_addr;
    logic        w_aw_done;
    logic        w_w_done;
    logic        w_tmo_hit;
    logic        w_unused_cfg;

    assign w_rw        = r_cmd[7];
    assign w_fix       = r_cmd[6];
    assign w_size      = r_cmd[5:4];
    assign w_lane      = r_addr[1:0] + r_j;
    assign w_misal     = ((w_size == 2'b01) && r_addr[0]) ||
                         ((w_size == 2'b10) && (r_addr[1:0] != 2'b00));
    assign w_next_addr = w_fix ? r_addr
                               : r_addr + {30'd0, w_bpb_m1} + 32'd1;
    assign w_aw_done   = !r_awvalid || m_awready;
    assign w_w_done    = !r_wvalid || m_wready;

    // Bytes-per-beat and write strobe for the current beat address.
    always_comb begin
        w_bpb_m1 = 2'd3;
        w_strb   = 4'b1111;
        unique case (w_size)
            2'b00: begin
                w_bpb_m1 = 2'd0;
                w_strb   = 4'b0001 << r_addr[1:0];
            end
            2'b01: begin
                w_bpb_m1 = 2'd1;
                w_strb   = r_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_bpb_m1 = 2'd3;
                w_strb   = 4'b1111;
            end
        endcase
    end

`ifdef CMD_EXEC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1) + 1;

    logic [TW-1:0] r_tmo;
    state_t        r_st_d;
    logic [TW-1:0] w_cnt;
    logic          w_phase;

    assign w_cnt     = (r_state == r_st_d) ? r_tmo + TW'(1) : '0;
    assign w_phase   = (r_state == S_AWW) || (r_state == S_B) ||
                       (r_state == S_AR)  || (r_state == S_R);
    assign w_tmo_hit = w_phase && (w_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign w_unused_cfg = (MAX_BEATS == 0);

    // Cycles spent in the current state; restarts on every state change.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tmo  <= '0;
            r_st_d <= S_IDLE;
        end else begin
            r_tmo  <= w_cnt;
            r_st_d <= r_state;
        end
    end
`else
    assign w_tmo_hit    = 1'b0;
    assign w_unused_cfg = (MAX_BEATS == 0) || (TIMEOUT_CYCLES == 0);
`endif

    // Frame sequencer: checks, AXI phases, response bytes, completion.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state          <= S_IDLE;
            r_cmd            <= '0;
            r_addr           <= '0;
            r_beat           <= '0;
            r_beats          <= '0;
            r_j              <= '0;
            r_rcnt           <= '0;
            r_rdata          <= '0;
            r_status         <= '0;
            r_done_valid     <= 1'b0;
            r_frame_consumed <= 1'b0;
            r_data_rd_idx    <= '0;
            r_resp_wr_en     <= 1'b0;
            r_resp_wr_idx    <= '0;
            r_resp_wr_byte   <= '0;
            r_awaddr         <= '0;
            r_awvalid        <= 1'b0;
            r_wdata          <= '0;
            r_wstrb          <= '0;
            r_wvalid         <= 1'b0;
            r_bready         <= 1'b0;
            r_araddr         <= '0;
            r_arvalid        <= 1'b0;
            r_rready         <= 1'b0;
        end else begin
            r_frame_consumed <= 1'b0;
            r_resp_wr_en     <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (frame_valid && !r_done_valid) begin
                        r_cmd   <= cmd_reg;
                        r_addr  <= addr_reg;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_beat        <= '0;
                    r_beats       <= '0;
                    r_j           <= '0;
                    r_rcnt        <= '0;
                    r_data_rd_idx <= '0;
                    if (w_size == 2'b11) begin
                        r_status <= ST_LEN;
                        r_state  <= S_DONE;
                    end else if (w_misal) begin
                        r_status <= ST_ALIGN;
                        r_state  <= S_DONE;
                    end else if (w_rw) begin
                        r_araddr  <= r_addr;
                        r_arvalid <= 1'b1;
                        r_state   <= S_AR;
                    end else begin
                        r_wdata <= '0;
                        r_state <= S_WLOAD;
                    end
                end
                S_WLOAD: begin
                    r_wdata[{w_lane, 3'b000} +: 8] <= data_rd_byte;
                    r_data_rd_idx <= r_data_rd_idx + 6'd1;
                    r_j           <= r_j + 2'd1;
                    if (r_j == w_bpb_m1) begin
                        r_j       <= '0;
                        r_awaddr  <= r_addr;
                        r_wstrb   <= w_strb;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= S_AWW;
                    end
                end
                S_AWW: begin
                    if (m_awready) r_awvalid <= 1'b0;
                    if (m_wready)  r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= S_B;
                    end else if (w_tmo_hit) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b0;
                        r_status  <= ST_TMO;
                        r_state   <= S_DONE;
                    end
                end
                S_B: begin
                    if (m_bvalid) begin
                        r_bready <= 1'b0;
                        if (m_bresp != 2'b00) begin
                            r_status <= ST_AXI;
                            r_state  <= S_DONE;
                        end else begin
                            r_beats <= r_beats + 5'd1;
                            r_state <= S_NEXT;
                        end
                    end else if (w_tmo_hit) begin
                        r_bready <= 1'b0;
                        r_status <= ST_TMO;
                        r_state  <= S_DONE;
                    end
                end
                S_AR: begin
                    if (m_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_R;
                    end else if (w_tmo_hit) begin
                        r_arvalid <= 1'b0;
                        r_status  <= ST_TMO;
                        r_state   <= S_DONE;
                    end
                end
                S_R: begin
                    if (m_rvalid) begin
                        r_rready <= 1'b0;
                        if (m_rresp != 2'b00) begin
                            r_status <= ST_AXI;
                            r_state  <= S_DONE;
                        end else begin
                            r_rdata <= m_rdata;
                            r_j     <= '0;
                            r_state <= S_RWR;
                        end
                    end else if (w_tmo_hit) begin
                        r_rready <= 1'b0;
                        r_status <= ST_TMO;
                        r_state  <= S_DONE;
                    end
                end
                S_RWR: begin
                    r_resp_wr_en   <= 1'b1;
                    r_resp_wr_idx  <= r_rcnt;
                    r_resp_wr_byte <= r_rdata[{w_lane, 3'b000} +: 8];
                    r_rcnt         <= r_rcnt + 6'd1;
                    r_j            <= r_j + 2'd1;
                    if (r_j == w_bpb_m1) begin
                        r_j     <= '0;
                        r_beats <= r_beats + 5'd1;
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (r_beat == r_cmd[3:0]) begin
                        r_status <= ST_OK;
                        r_state  <= S_DONE;
                    end else begin
                        r_beat <= r_beat + 4'd1;
                        r_addr <= w_next_addr;
                        if (w_rw) begin
                            r_araddr  <= w_next_addr;
                            r_arvalid <= 1'b1;
                            r_state   <= S_AR;
                        end else begin
                            r_wdata <= '0;
                            r_state <= S_WLOAD;
                        end
                    end
                end
                S_DONE: begin
                    r_frame_consumed <= 1'b1;
                    r_done_valid     <= 1'b1;
                    r_state          <= S_WACK;
                end
                S_WACK: begin
                    if (done_ready) begin
                        r_done_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign frame_consumed = r_frame_consumed;
    assign data_rd_idx    = r_data_rd_idx;
    assign resp_wr_en     = r_resp_wr_en;
    assign resp_wr_idx    = r_resp_wr_idx;
    assign resp_wr_byte   = r_resp_wr_byte;
    assign done_valid     = r_done_valid;
    assign done_status    = r_status;
    assign done_beats     = r_beats;
    assign m_awaddr       = r_awaddr;
    assign m_awvalid      = r_awvalid;
    assign m_wdata        = r_wdata;
    assign m_wstrb        = r_wstrb;
    assign m_wvalid       = r_wvalid;
    assign m_bready       = r_bready;
    assign m_araddr       = r_araddr;
    assign m_arvalid      = r_arvalid;
    assign m_rready       = r_rready;

endmodule
